// File: rtl/alu_seq_pkg.sv
// Shared command encodings, FSM state type and error-bit positions for the
// ALU operation sequencer.
package alu_seq_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_MUL = 4'd3;
  localparam logic [3:0] CMD_DIV = 4'd4;
  localparam logic [3:0] CMD_MOD = 4'd5;

  localparam int ERR_ILL = 2;
  localparam int ERR_DBZ = 1;
  localparam int ERR_OVF = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic is_legal(input logic [3:0] cmd);
    return (cmd >= CMD_ADD) && (cmd <= CMD_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between an operation producer and the sequencer.
// Both channels are valid/ready: a beat transfers on a rising edge where
// valid and ready are both high; the sender holds its payload stable and
// keeps valid high until that edge, and valid never waits on ready.
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_chain;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_err;

  modport master (
    output req_valid, req_cmd, req_a, req_b, req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_rsp_qualify.sv
// Turns raw ALU outputs into the response word: zero-extends 16-bit results,
// forces zero on divide-by-zero and keeps only the error flags meaningful for the command.
module alu_rsp_qualify
  import alu_seq_pkg::*;
(
  input  logic [3:0]  cmd_i,
  input  logic [31:0] alu_result_i,
  input  logic [1:0]  alu_error_i,
  output logic [31:0] result_o,
  output logic [2:0]  err_o
);

  always_comb begin
    result_o = '0;
    err_o    = '0;
    case (cmd_i)
      CMD_ADD, CMD_SUB: begin
        result_o       = {16'b0, alu_result_i[15:0]};
        err_o[ERR_OVF] = alu_error_i[0];
      end
      CMD_MUL: result_o = alu_result_i;
      CMD_DIV, CMD_MOD: begin
        if (alu_error_i[1]) err_o[ERR_DBZ] = 1'b1;
        else                result_o = {16'b0, alu_result_i[15:0]};
      end
      default: err_o[ERR_ILL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Feeds one operation at a time into the combinational ALU, holds its inputs
// for the settle window, then returns the qualified result on the response channel.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_if.slave         bus,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [3:0]       alu_cmd,
  input  logic [31:0]      alu_result,
  input  logic [1:0]       alu_error,
  input  logic             clr_err,
  output logic [15:0]      acc,
  output logic [2:0]       sticky_err,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state_o
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [SC_W-1:0]   cnt_q, cnt_d;
  logic [15:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d, acc_q, acc_d;
  logic [3:0]        alu_cmd_q, alu_cmd_d, qual_cmd;
  logic [31:0]       rsp_result_q, rsp_result_d, q_result;
  logic [2:0]        rsp_err_q, rsp_err_d, sticky_q, sticky_d, q_err;
  logic [CNT_W-1:0]  op_count_q, op_count_d;
  logic              capture;

  // An illegal command is qualified straight off the request bus in IDLE.
  assign qual_cmd = (state_q == IDLE) ? bus.req_cmd : alu_cmd_q;

  alu_rsp_qualify u_qualify (
    .cmd_i        (qual_cmd),
    .alu_result_i (alu_result),
    .alu_error_i  (alu_error),
    .result_o     (q_result),
    .err_o        (q_err)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cmd_d    = alu_cmd_q;
    acc_d        = acc_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    sticky_d     = clr_err ? 3'b000 : sticky_q;
    op_count_d   = op_count_q;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          alu_a_d = bus.req_chain ? acc_q : bus.req_a;
          alu_b_d = bus.req_b;
          cnt_d   = SC_W'(SETTLE_CYCLES - 1);
          if (is_legal(bus.req_cmd)) begin
            alu_cmd_d = bus.req_cmd;
            state_d   = SETTLE;
          end else begin
            capture = 1'b1;
            state_d = RESP;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - SC_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          alu_cmd_d  = CMD_NOP;
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      rsp_result_d = q_result;
      rsp_err_d    = q_err;
      sticky_d     = sticky_d | q_err;
      if (q_err == 3'b000) acc_d = q_result[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cmd_q    <= CMD_NOP;
      acc_q        <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= '0;
      sticky_q     <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cmd_q    <= alu_cmd_d;
      acc_q        <= acc_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      sticky_q     <= sticky_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE) && !rst;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_cmd        = alu_cmd_q;
  assign acc            = acc_q;
  assign sticky_err     = sticky_q;
  assign op_count       = op_count_q;
  assign dbg_state_o    = state_q;

endmodule
